hdlc_frame_tx: RTL

Parametrised HDLC frame transmitter with an internal payload FIFO. It accepts bytes from an upstream byte source, typically the UART `rx` receiver, and buffers up to `MAX_LEN` of them. It then emits one complete frame on the RS-485 line: opening flag, address, control, 1..`MAX_LEN` payload bytes, CRC-16 FCS, closing flag. Zero-bit insertion and bit-rate pacing happen on the fly. It replaces the fixed one-byte, 64-bit package/CRC/stuff/send chain.

---
 rtl/hdlc_frame_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hdlc_frame_tx.sv
// HDLC frame transmitter with payload FIFO, CRC-16/X-25 FCS,
// zero-bit insertion and bit-rate pacing.
module hdlc_frame_tx #(
  parameter logic [7:0] ADDR      = 8'h01,
  parameter logic [7:0] CTRL      = 8'h00,
  parameter int         MAX_LEN   = 16,
  parameter int         BIT_DIV   = 5208,
  parameter bit         AUTO_SEND = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_LEN);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] OPEN   = 3'd1;
  localparam logic [2:0] ADR    = 3'd2;
  localparam logic [2:0] CTL    = 3'd3;
  localparam logic [2:0] PAY    = 3'd4;
  localparam logic [2:0] FCS_LO = 3'd5;
  localparam logic [2:0] FCS_HI = 3'd6;
  localparam logic [2:0] CLOSE  = 3'd7;

  logic [7:0]    mem [MAX_LEN];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] rem;
  logic [2:0]    state;
  logic [2:0]    bidx;
  logic [2:0]    ones;
  logic [2:0]    ones_n;
  logic [DW-1:0] div;
  logic [7:0]    sh;
  logic [15:0]   crc;
  logic          stuffing;
  logic          wr;
  logic          rd;
  logic          start;
  logic          bit_end;
  logic          region;
  logic          do_stuff;
  logic          adv;
  logic          last;
  logic [7:0]    rd_data;

  // reflected CRC-16/X-25, one octet LSB-first
  function automatic logic [15:0] crc8(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
    return r;
  endfunction

  assign in_rdy  = (count != FULL);
  assign rd_data = mem[rptr];

  always_comb begin
    wr       = in_vld && in_rdy;
    start    = (state == IDLE) &&
               ((send && count != '0) ||
                (AUTO_SEND && count == FULL));
    bit_end  = (div == DIV_MAX);
    region   = (state >= ADR) && (state <= FCS_HI);
    ones_n   = tx ? ones + 3'd1 : 3'd0;
    do_stuff = bit_end && region && !stuffing &&
               (ones_n == 3'd5);
    adv      = (state != IDLE) && bit_end && !do_stuff;
    last     = (bidx == 3'd7);
    rd       = adv && last &&
               ((state == CTL) ||
                (state == PAY && rem != '0));
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (rd)
        rptr <= rptr + 1'b1;
      if (wr && !rd)
        count <= count + 1'b1;
      else if (rd && !wr)
        count <= count - 1'b1;
      if (in_vld && !in_rdy)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      div      <= '0;
      bidx     <= '0;
      ones     <= '0;
      stuffing <= 1'b0;
      sh       <= '0;
      crc      <= '1;
      rem      <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        div <= '0;
        if (start) begin
          state    <= OPEN;
          busy     <= 1'b1;
          sh       <= 8'h7E;
          bidx     <= '0;
          tx       <= 1'b0;
          ones     <= '0;
          stuffing <= 1'b0;
          rem      <= count;
        end
      end else if (!bit_end) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (do_stuff) begin
          // stuff bit holds the octet index in place
          tx       <= 1'b0;
          stuffing <= 1'b1;
          ones     <= '0;
        end else begin
          stuffing <= 1'b0;
          if (region && !stuffing)
            ones <= ones_n;
          if (!last) begin
            bidx <= bidx + 3'd1;
            tx   <= sh[bidx + 3'd1];
          end else begin
            bidx <= '0;
            case (state)
              OPEN: begin
                state <= ADR;
                sh    <= ADDR;
                tx    <= ADDR[0];
                crc   <= crc8(16'hFFFF, ADDR);
              end
              ADR: begin
                state <= CTL;
                sh    <= CTRL;
                tx    <= CTRL[0];
                crc   <= crc8(crc, CTRL);
              end
              CTL, PAY: begin
                if (rem != '0) begin
                  state <= PAY;
                  sh    <= rd_data;
                  tx    <= rd_data[0];
                  crc   <= crc8(crc, rd_data);
                  rem   <= rem - 1'b1;
                end else begin
                  state <= FCS_LO;
                  sh    <= ~crc[7:0];
                  tx    <= ~crc[0];
                end
              end
              FCS_LO: begin
                state <= FCS_HI;
                sh    <= ~crc[15:8];
                tx    <= ~crc[8];
              end
              FCS_HI: begin
                state <= CLOSE;
                sh    <= 8'h7E;
                tx    <= 1'b0;
              end
              CLOSE: begin
                state <= IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: begin
                state <= IDLE;
                tx    <= 1'b1;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule
